// File: rtl/clk_div_mux.sv
//==============================================================================
// clk_div_mux : glitch-free selectable power-of-two clock divider
// Rev 1.0     : initial release
//==============================================================================
`default_nettype none

module clk_div_mux #(
  parameter  int DIV_LOG2_MAX = 4,
  parameter  int RESET_SEL    = 0,
  parameter  int RESET_EN     = 1,
  localparam int SEL_W        = (DIV_LOG2_MAX > 1) ? $clog2(DIV_LOG2_MAX) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_en,
  output logic             req_ready,
  output logic             req_err,
  output logic [SEL_W-1:0] cur_sel,
  output logic             cur_en,
  output logic             sw_done,
  output logic             out_clk,
  output logic             out_ce
);

  localparam logic [31:0] C_NRATIO = 32'(DIV_LOG2_MAX);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_LOG2_MAX-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d, pend_sel_q, pend_sel_d;
  logic                    en_q, en_d, pend_en_q, pend_en_d;
  logic                    clk_q, clk_d, ce_q, ce_d;
  logic                    err_q, err_d, done_q, done_d;
  logic                    wrap, in_range, phase_bit, phase_zero;

  // A select field wide enough to encode every ratio can never be out of range.
  generate
    if ((1 << SEL_W) > DIV_LOG2_MAX) begin : g_range_chk
      assign in_range = (32'(req_sel) < C_NRATIO);
    end else begin : g_range_all
      assign in_range = 1'b1;
    end
  endgenerate

  assign wrap = &cnt_q;

  always_comb begin
    cnt_d      = cnt_q + DIV_LOG2_MAX'(1);
    state_d    = state_q;
    sel_d      = sel_q;
    en_d       = en_q;
    pend_sel_d = pend_sel_q;
    pend_en_d  = pend_en_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (in_range) begin
            pend_sel_d = req_sel;
            pend_en_d  = req_en;
            state_d    = S_PEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (wrap) begin
          sel_d   = pend_sel_q;
          en_d    = pend_en_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output phase is taken from the post-edge counter and settings, so the
    // switch edge already drives the new ratio.
    phase_bit  = 1'b0;
    phase_zero = 1'b1;
    for (int unsigned i = 0; i < C_NRATIO; i++) begin
      if (i == 32'(sel_d)) phase_bit = cnt_d[i];
      if ((i <= 32'(sel_d)) && cnt_d[i]) phase_zero = 1'b0;
    end
    clk_d = en_d & ~phase_bit;
    ce_d  = en_d & phase_zero;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '1;
      sel_q      <= SEL_W'(RESET_SEL);
      en_q       <= (RESET_EN != 0);
      pend_sel_q <= '0;
      pend_en_q  <= 1'b0;
      clk_q      <= 1'b0;
      ce_q       <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      pend_sel_q <= pend_sel_d;
      pend_en_q  <= pend_en_d;
      clk_q      <= clk_d;
      ce_q       <= ce_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign req_err   = err_q;
  assign cur_sel   = sel_q;
  assign cur_en    = en_q;
  assign sw_done   = done_q;
  assign out_clk   = clk_q;
  assign out_ce    = ce_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_mux.sv
//==============================================================================
// tb_clk_div_mux : randomized bench for clk_div_mux against a behavioural model
// Rev 1.0        : initial release
//==============================================================================
`default_nettype none

module tb_clk_div_mux;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic       req_en = 1'b0;
  logic       req_ready, req_err, cur_en, sw_done, out_clk, out_ce;
  logic [1:0] cur_sel;

  // Second instance with three ratios so an out-of-range select is encodable.
  logic       v3 = 1'b0;
  logic [1:0] s3 = 2'd0;
  logic       e3 = 1'b0;
  logic       r3_ready, r3_err, r3_en, r3_done, r3_clk, r3_ce;
  logic [1:0] r3_sel;

  clk_div_mux #(.DIV_LOG2_MAX(N)) u_dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_en(req_en), .req_ready(req_ready), .req_err(req_err), .cur_sel(cur_sel),
    .cur_en(cur_en), .sw_done(sw_done), .out_clk(out_clk), .out_ce(out_ce)
  );

  clk_div_mux #(.DIV_LOG2_MAX(3)) u_dut3 (
    .clk(clk), .arst_n(arst_n), .req_valid(v3), .req_sel(s3),
    .req_en(e3), .req_ready(r3_ready), .req_err(r3_err), .cur_sel(r3_sel),
    .cur_en(r3_en), .sw_done(r3_done), .out_clk(r3_clk), .out_ce(r3_ce)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_cnt, m_sel, m_psel;
  bit m_en, m_pen, m_pend, m_err, m_done, m_clk, m_ce;

  logic [7:0] obs;
  assign obs = {out_clk, out_ce, req_ready, req_err, sw_done, cur_sel, cur_en};

  function automatic logic [7:0] exp_vec();
    return {m_clk, m_ce, !m_pend, m_err, m_done, m_sel[1:0], m_en};
  endfunction

  task automatic model_reset();
    m_cnt = (1 << N) - 1; m_sel = 0; m_en = 1'b1; m_pend = 1'b0;
    m_err = 1'b0; m_done = 1'b0; m_clk = 1'b0; m_ce = 1'b0;
  endtask

  // Advance one source-clock edge; inputs are stable across the edge.
  task automatic tick();
    @(posedge clk);
    if (!arst_n) begin
      model_reset();
    end else begin
      int  period;
      bit  wrap;
      m_cnt  = (m_cnt + 1) % (1 << N);
      wrap   = (m_cnt == 0);
      m_err  = 1'b0;
      m_done = 1'b0;
      if (m_pend && wrap) begin
        m_sel = m_psel; m_en = m_pen; m_pend = 1'b0; m_done = 1'b1;
      end else if (!m_pend && req_valid) begin
        if (int'(req_sel) < N) begin
          m_pend = 1'b1; m_psel = int'(req_sel); m_pen = req_en;
        end else begin
          m_err = 1'b1;
        end
      end
      period = 2 << m_sel;
      m_clk  = m_en && ((m_cnt % period) < (period / 2));
      m_ce   = m_en && ((m_cnt % period) == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    int ces;
    arst_n = 1'b0; req_valid = 1'b1; req_sel = 2'd3; req_en = 1'b0;
    model_reset();
    repeat (4) begin
      tick();
      n_vec++;
      if (obs !== 8'b0010_0001) begin
        n_bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 8'b0010_0001);
      end
    end
    req_valid = 1'b0;
    arst_n = 1'b1;
    ces = 0;
    repeat (8) begin
      tick();
      ces += int'(out_ce);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL reset_release got=%b exp=%b", obs, exp_vec());
      end
    end
    n_vec++;
    if (ces != 4) begin
      n_bad++; $display("FAIL reset_ce_count got=%0d exp=4", ces);
    end
  endtask

  task automatic test_switch();
    int lowcnt;
    for (int k = 0; k < 40 && !(m_cnt == 5 && !m_pend); k++) tick();
    n_vec++;
    if (!(m_cnt == 5 && !m_pend)) begin
      n_bad++; $display("FAIL switch_align got=%0d exp=5", m_cnt);
    end
    req_valid = 1'b1; req_sel = 2'd2; req_en = 1'b1;
    tick();
    req_valid = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL switch_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
      if (k < 20 && !req_ready) lowcnt++;
      tick();
    end
    n_vec++;
    if (lowcnt != 10) begin
      n_bad++; $display("FAIL switch_ready_low got=%0d exp=10", lowcnt);
    end
  endtask

  task automatic test_pend_hold();
    int lat;
    req_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      req_sel = 2'($urandom_range(3, 0));
      req_en  = ($urandom_range(3, 0) != 0);
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL pend_hold_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 60 && !(m_cnt == 15 && !m_pend); k++) tick();
    req_valid = 1'b1; req_sel = 2'($urandom_range(3, 0)); req_en = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !sw_done; k++) begin
      tick();
      lat++;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL wrap_accept_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
    n_vec++;
    if (lat != 16) begin
      n_bad++; $display("FAIL wrap_accept_latency got=%0d exp=16", lat);
    end
  endtask

  task automatic test_disable();
    int ces_off;
    for (int k = 0; k < 40 && m_pend; k++) tick();
    req_valid = 1'b1; req_sel = 2'd1; req_en = 1'b0;
    tick();
    req_valid = 1'b0;
    ces_off = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!m_en && (out_ce || out_clk)) ces_off++;
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL disable_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
    n_vec++;
    if (ces_off != 0) begin
      n_bad++; $display("FAIL disable_silent got=%0d exp=0", ces_off);
    end
    req_valid = 1'b1; req_sel = 2'd3; req_en = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 56; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL reenable_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom_range(3, 0) == 0);
      req_sel   = 2'($urandom_range(3, 0));
      req_en    = ($urandom_range(3, 0) != 0);
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_err();
    logic [1:0] sel_before;
    sel_before = r3_sel;
    v3 = 1'b1; s3 = 2'd3; e3 = 1'b0;
    tick();
    v3 = 1'b0;
    n_vec++;
    if ({r3_err, r3_ready, r3_sel, r3_en} !== {1'b1, 1'b1, sel_before, 1'b1}) begin
      n_bad++; $display("FAIL err_pulse got=%b exp=%b",
                        {r3_err, r3_ready, r3_sel, r3_en}, {1'b1, 1'b1, sel_before, 1'b1});
    end
    tick();
    n_vec++;
    if ({r3_err, r3_ready} !== 2'b01) begin
      n_bad++; $display("FAIL err_clear got=%b exp=01", {r3_err, r3_ready});
    end
    v3 = 1'b1; s3 = 2'd2; e3 = 1'b1;
    tick();
    v3 = 1'b0;
    n_vec++;
    if ({r3_err, r3_ready} !== 2'b00) begin
      n_bad++; $display("FAIL err_inrange got=%b exp=00", {r3_err, r3_ready});
    end
  endtask

  task automatic test_reset_mid_pend();
    int dones;
    for (int k = 0; k < 40 && m_pend; k++) tick();
    req_valid = 1'b1; req_sel = 2'd0; req_en = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 40 && !(m_cnt == 0 && !m_pend); k++) tick();
    req_valid = 1'b1; req_sel = 2'd3; req_en = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8 && !m_clk; k++) tick();
    n_vec++;
    if ({out_clk, req_ready} !== 2'b10) begin
      n_bad++; $display("FAIL midpend_setup got=%b exp=10", {out_clk, req_ready});
    end
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs !== 8'b0010_0001) begin
      n_bad++; $display("FAIL midpend_async got=%b exp=%b", obs, 8'b0010_0001);
    end
    tick();
    arst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      dones += int'(sw_done);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL midpend_after_cycle%0d got=%b exp=%b", k, obs, exp_vec());
      end
    end
    n_vec++;
    if (dones != 0) begin
      n_bad++; $display("FAIL midpend_no_done got=%0d exp=0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_pend_hold();
    test_disable();
    test_err();
    test_random();
    test_reset_mid_pend();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
